// File: rtl/res_word_reader.sv
// Unpacks 32-bit PE result words from the result memory into a valid/ready stream of 8-bit pixels.
// Define RD_PREFETCH_EN to overlap the next word's read with byte 3 of the current word.
module res_word_reader #(
    parameter int MAX_MEM_SIZE = 128,
    parameter int ADDR_W       = 8,
    parameter int PIX_IDX_W    = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_i,        // asynchronous, active low
    input  logic                 start_i,
    input  logic [ADDR_W-1:0]    base_adr_i,
    input  logic [ADDR_W-1:0]    num_words_i,
    output logic                 rd_en_o,
    output logic [ADDR_W-1:0]    rd_adr_o,
    input  logic [31:0]          rd_data_i,
    output logic                 pix_valid_o,
    input  logic                 pix_ready_i,
    output logic [7:0]           pix_data_o,
    output logic [PIX_IDX_W-1:0] pix_index_o,
    output logic                 busy_o,
    output logic                 done_o
);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_LOAD, S_EMIT, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, nwords_q, word_cnt_q;
    logic [1:0]        byte_cnt_q;
    logic [31:0]       word_q;
    logic [31:0]       word_src;
    logic [ADDR_W:0]   adr_sum;
    logic              xfer, last_byte, last_word, pf_req;

    assign xfer      = (state_q == S_EMIT) && pix_ready_i;
    assign last_byte = (byte_cnt_q == 2'd3);
    assign last_word = (word_cnt_q == nwords_q - ADDR_W'(1));

`ifdef RD_PREFETCH_EN
    logic [31:0] next_q;
    logic        pf_issued_q, pf_arrive_q, use_rd_q;

    // One read per word, issued the first cycle byte 3 is on the bus.
    assign pf_req   = (state_q == S_EMIT) && last_byte && !pf_issued_q && !last_word;
    // If byte 3 left in the issuing cycle, the new word is still on rd_data.
    assign word_src = use_rd_q ? rd_data_i : word_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            next_q      <= '0;
            pf_issued_q <= 1'b0;
            pf_arrive_q <= 1'b0;
            use_rd_q    <= 1'b0;
        end else begin
            pf_arrive_q <= pf_req;
            use_rd_q    <= xfer && last_byte && pf_req;
            if (pf_arrive_q) next_q <= rd_data_i;
            if (xfer && last_byte) pf_issued_q <= 1'b0;
            else if (pf_req)       pf_issued_q <= 1'b1;
        end
    end
`else
    assign pf_req   = 1'b0;
    assign word_src = word_q;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start_i) state_d = (num_words_i == '0) ? S_DONE : S_READ;
            S_READ: state_d = S_LOAD;
            S_LOAD: state_d = S_EMIT;
            S_EMIT: begin
                if (xfer && last_byte) begin
                    if (last_word) state_d = S_DONE;
`ifdef RD_PREFETCH_EN
                    else           state_d = S_EMIT;
`else
                    else           state_d = S_READ;
`endif
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_en_o     = 1'b0;
        pix_valid_o = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        unique case (state_q)
            S_READ: begin rd_en_o = 1'b1; busy_o = 1'b1; end
            S_LOAD: busy_o = 1'b1;
            S_EMIT: begin pix_valid_o = 1'b1; busy_o = 1'b1; rd_en_o = pf_req; end
            S_DONE: done_o = 1'b1;
            default: ;
        endcase
    end

    assign adr_sum     = {1'b0, base_q} + {1'b0, word_cnt_q} + {{ADDR_W{1'b0}}, pf_req};
    assign rd_adr_o    = ADDR_W'(adr_sum % (ADDR_W+1)'(MAX_MEM_SIZE));
    assign pix_data_o  = word_src[8*byte_cnt_q +: 8];
    assign pix_index_o = PIX_IDX_W'({word_cnt_q, byte_cnt_q});

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            base_q     <= '0;
            nwords_q   <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
        end else begin
            if (state_q == S_IDLE && start_i) begin
                base_q     <= base_adr_i;
                nwords_q   <= num_words_i;
                word_cnt_q <= '0;
                byte_cnt_q <= '0;
            end
            if (state_q == S_LOAD) begin
                word_q     <= rd_data_i;
                byte_cnt_q <= '0;
            end
`ifdef RD_PREFETCH_EN
            else if (use_rd_q) word_q <= rd_data_i;
            else if (xfer && last_byte && !last_word) word_q <= pf_arrive_q ? rd_data_i : next_q;
`endif
            // Byte 3 wraps the 2-bit counter back to 0 for the next word.
            if (xfer) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
                if (last_byte && !last_word) word_cnt_q <= word_cnt_q + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_res_word_reader.sv
// Randomized bench for res_word_reader: a memory model plus an expected pixel/address stream
// built from the word layout, with backpressure, wrap, zero-length and reset-abort cases.
module tb_res_word_reader;
    localparam int MEM = 128;
    localparam int AW  = 8;
    localparam int PW  = 10;

    logic          clk = 1'b0, rst_n = 1'b1, start = 1'b0, pix_ready = 1'b0;
    logic          rd_en, pix_valid, busy, done;
    logic [AW-1:0] base_adr = '0, num_words = '0, rd_adr;
    logic [31:0]   rd_data;
    logic [7:0]    pix_data;
    logic [PW-1:0] pix_index;
    logic [31:0]   mem [MEM];
    int            nchk = 0, nerr = 0;

    res_word_reader #(.MAX_MEM_SIZE(MEM), .ADDR_W(AW), .PIX_IDX_W(PW)) dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .base_adr_i(base_adr),
        .num_words_i(num_words), .rd_en_o(rd_en), .rd_adr_o(rd_adr), .rd_data_i(rd_data),
        .pix_valid_o(pix_valid), .pix_ready_i(pix_ready), .pix_data_o(pix_data),
        .pix_index_o(pix_index), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    // Read data is only meaningful the cycle after rd_en; junk otherwise.
    always @(posedge clk) rd_data <= rd_en ? mem[rd_adr] : $urandom;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_xfer(input int base, input int n, input int mode);
        int         exp_adr[$], exp_idx[$], got_adr[$];
        logic [7:0] exp_pix[$];
        logic [31:0] wd;
        logic [7:0] prev_data;
        int         prev_idx, cyc, first, last, done_cyc, bad_busy, bad_hold, extra, nvalid, a;
        bit         prev_hold, tog, rdy;
        for (int w = 0; w < n; w++) begin
            a  = (base + w) % MEM;
            wd = mem[a];
            exp_adr.push_back(a);
            for (int b = 0; b < 4; b++) begin
                exp_pix.push_back(wd[8*b +: 8]);
                exp_idx.push_back((4*w + b) % (1 << PW));
            end
        end
        base_adr = AW'(base); num_words = AW'(n); start = 1'b1; pix_ready = 1'b0;
        tick();
        start = 1'b0;
        cyc = 1; first = -1; last = -1; done_cyc = -1;
        bad_busy = 0; bad_hold = 0; extra = 0; nvalid = 0; prev_hold = 0; tog = 1;
        while (cyc < 4000) begin
            if (rd_en) got_adr.push_back(int'(rd_adr));
            if (done) begin
                done_cyc = cyc;
                chk("busy_in_done", busy, 0);
                break;
            end
            if (busy !== (n > 0)) bad_busy++;
            if (prev_hold && !pix_valid) bad_hold++;
            if (pix_valid) begin
                nvalid++;
                if (prev_hold && (pix_data !== prev_data || int'(pix_index) != prev_idx)) bad_hold++;
                case (mode)
                    0:       rdy = 1'b1;
                    1:       begin rdy = tog; tog = !tog; end
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                pix_ready = rdy;
                if (rdy) begin
                    if (exp_pix.size() == 0) extra++;
                    else begin
                        chk($sformatf("pix_data[%0d]", exp_idx[0]), pix_data, exp_pix.pop_front());
                        chk("pix_index", pix_index, exp_idx.pop_front());
                    end
                    if (first < 0) first = cyc;
                    last = cyc;
                end
                prev_hold = !rdy; prev_data = pix_data; prev_idx = int'(pix_index);
            end else begin
                prev_hold = 0;
                pix_ready = 1'($urandom_range(0, 1));
            end
            // Stray starts and changing parameters must not disturb the transfer.
            start = 1'($urandom_range(0, 1)); base_adr = AW'($urandom); num_words = AW'($urandom);
            tick();
            cyc++;
        end
        start = 1'b0; pix_ready = 1'b0;
        if (done_cyc < 0) chk("timeout", 1, 0);
        chk("rd_count", got_adr.size(), n);
        for (int i = 0; i < n && i < got_adr.size(); i++) chk($sformatf("rd_adr[%0d]", i), got_adr[i], exp_adr[i]);
        chk("pix_left", exp_pix.size(), 0);
        chk("extra_pix", extra, 0);
        chk("busy_level", bad_busy, 0);
        chk("hold_stable", bad_hold, 0);
        if (n == 0) begin
            chk("zero_done_cyc", done_cyc, 1);
            chk("zero_valid", nvalid, 0);
        end else begin
            chk("done_after_last", done_cyc, last + 1);
            if (mode == 0) begin
                chk("first_pix_cyc", first, 3);
`ifdef RD_PREFETCH_EN
                chk("last_pix_cyc", last, 4*n + 2);
`else
                chk("last_pix_cyc", last, 6*n);
`endif
            end
        end
        tick();
        chk("done_pulse", {done, busy}, 2'b00);
    endtask

    task automatic abort_test;
        bit reached, saw_done;
        reached = 0; saw_done = 0;
        base_adr = 8'd40; num_words = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            pix_ready = 1'b1;
            if (pix_valid && pix_index >= 4) begin reached = 1; break; end
            tick();
        end
        chk("abort_reach_word1", reached, 1);
        #2 rst_n = 1'b0;
        #1 chk("abort_outs", {rd_en, pix_valid, busy, done, rd_adr, pix_data, pix_index}, '0);
        pix_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (done) saw_done = 1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done || busy) saw_done = 1;
        end
        chk("abort_no_done", saw_done, 0);
    endtask

    initial begin
        for (int i = 0; i < MEM; i++) mem[i] = $urandom;
        mem[5] = 32'hDDCCBBAA;
        #1 rst_n = 1'b0;
        #2 chk("reset_outs", {rd_en, pix_valid, busy, done, rd_adr, pix_data, pix_index}, '0);
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        run_xfer(5, 1, 0);
        run_xfer(10, 3, 1);
        run_xfer(77, 0, 0);
        run_xfer(126, 4, 0);
        run_xfer(126, 4, 2);
        abort_test();
        run_xfer(33, 2, 0);
        for (int r = 0; r < 8; r++)
            run_xfer($urandom_range(0, 255), $urandom_range(1, 8), $urandom_range(0, 2));
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/res_word_reader.md
Name: res_word_reader

Overview:
- Reads packed 32-bit PE result words from a result memory and unpacks each into four 8-bit pixels.
- Streams the pixels out over a valid/ready handshake, so the results of one layer can feed the image buffer of the next layer.
- Each word holds four bytes: byte index 0 is bits [7:0], byte 3 is bits [31:24].
- Sits between the PE result memory and the next-layer image loader.

Parameters:
- MAX_MEM_SIZE, 128, depth of the result memory in 32-bit words; the read address wraps modulo this value.
- ADDR_W, 8, width of the word address ports.
- PIX_IDX_W, 10, width of the linear output pixel index.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a transfer; sampled only in IDLE.
- base_adr  input  ADDR_W  first word address; sampled on an accepted start.
- num_words  input  ADDR_W  number of words to read; sampled on an accepted start.
- rd_en  output  1  memory read strobe.
- rd_adr  output  ADDR_W  memory read address.
- rd_data  input  32  read data; valid exactly 1 cycle after rd_en.
- pix_valid  output  1  pix_data and pix_index are valid.
- pix_ready  input  1  consumer accepts the pixel.
- pix_data  output  8  unpacked pixel.
- pix_index  output  PIX_IDX_W  linear byte index: word_cnt*4 + byte_cnt.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset values (rst low, asynchronous): state=IDLE; rd_en, pix_valid, busy, done = 0; rd_adr, pix_data, pix_index = 0; all counters and word registers = 0.
- States: IDLE, READ, LOAD, EMIT, DONE.
- IDLE: start=1 latches base_adr and num_words and clears word_cnt and byte_cnt.
  - If num_words==0, go to DONE; no read is issued.
  - Otherwise go to READ.
- READ: rd_en=1 for exactly one cycle; rd_adr=(base+word_cnt) mod MAX_MEM_SIZE; go to LOAD.
- LOAD: capture rd_data into word_reg; byte_cnt=0; go to EMIT.
- EMIT:
  - pix_valid=1; pix_data=word_reg[8*byte_cnt +: 8]; pix_index=word_cnt*4+byte_cnt.
  - A transfer occurs when pix_valid && pix_ready on a rising edge.
  - While pix_ready=0, pix_data and pix_index stay stable.
  - On a transfer with byte_cnt<3: byte_cnt increments.
  - On a transfer with byte_cnt==3: if word_cnt==num_words-1, go to DONE; otherwise word_cnt increments and state goes to READ.
- DONE: done=1 for one cycle; busy drops in the same cycle; go to IDLE.
- Latency: start accepted at edge 0 gives rd_en high in cycle 1, the capture in cycle 2, and the first pix_valid in cycle 3.
- Throughput without the optional feature: 6 cycles per word with pix_ready held at 1.
- start while not in IDLE is ignored; the latched parameters do not change mid-transfer.
- rd_adr wraps: base=126, num_words=4 reads addresses 126, 127, 0, 1.
- pix_index wraps modulo 2^PIX_IDX_W.
- Reset asserted mid-transfer aborts immediately to IDLE with the reset values; no done pulse is produced.

Optional Feature:
- Macro RD_PREFETCH_EN.
- Defined:
  - In EMIT, rd_en is pulsed for the next word in the first cycle that byte_cnt==3 is presented, but only if more words remain.
  - The returned data is captured into next_reg.
  - On the byte-3 transfer, word_reg<=next_reg and the block goes directly to EMIT byte 0 of the next word.
  - Sustained throughput is 4 cycles per word.
  - A stall on pix_ready does not re-issue the read.
- Undefined: next_reg is absent and the timing is exactly as in Behaviour.

Test Plan:
- Single word, no stall: mem[5]=32'hDDCCBBAA, base=5, num_words=1, pix_ready=1 -> rd_en once with rd_adr=5; pixels AA, BB, CC, DD with index 0..3 in cycles 3..6; done pulse in cycle 7.
- Multi-word backpressure: num_words=3, pix_ready toggling 1/0 -> 12 pixels in order, index 0..11; each pixel held stable through every ready=0 cycle; exactly 3 rd_en pulses.
- Zero length: start with num_words=0 -> no rd_en, no pix_valid; done one cycle after start.
- Wrap: base=126, num_words=4 -> rd_adr sequence 126, 127, 0, 1.
- Reset abort: rst low during EMIT of word 1 -> all outputs 0 immediately, no done; a new start then runs normally from its base.
- RD_PREFETCH_EN: 4 words with pix_ready=1 -> first pixel in cycle 3, last pixel in cycle 18, with no gaps between words.
